// File: rtl/mandel_status_pio_in.sv
//------------------------------------------------------------------------------
// mandel_status_pio_in : Avalon-MM input PIO with synchroniser, edge capture, irq
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mandel_status_pio_in #(
    parameter int WIDTH       = 32,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int c_WARM_MAX = SYNC_STAGES + 1;
    localparam int c_CNT_W    = $clog2(c_WARM_MAX + 1);

    localparam logic [1:0] c_ADDR_DATA = 2'd0;
    localparam logic [1:0] c_ADDR_MASK = 2'd2;
    localparam logic [1:0] c_ADDR_CAP  = 2'd3;

    logic [WIDTH-1:0]   r_sync [SYNC_STAGES];
    logic [WIDTH-1:0]   r_prev;
    logic [WIDTH-1:0]   r_mask;
    logic [WIDTH-1:0]   r_cap;
    logic [31:0]        r_readdata;
    logic [c_CNT_W-1:0] r_warm;

    logic [WIDTH-1:0]   w_sync;
    logic [WIDTH-1:0]   w_edge_raw;
    logic [WIDTH-1:0]   w_edge;
    logic [WIDTH-1:0]   w_clr;
    logic [WIDTH-1:0]   w_rd_sel;
    logic [31:0]        w_rd_ext;
    logic               w_wr;
    logic               w_rd;
    logic               w_warm_done;

    assign w_sync      = r_sync[SYNC_STAGES-1];
    assign w_wr        = chipselect & ~write_n;
    assign w_rd        = chipselect & write_n;
    assign w_warm_done = (r_warm == c_CNT_W'(c_WARM_MAX));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync;
        end
    end

    // Hold off edge detection until sync and prev both reflect real input,
    // so a line already high at reset release is not seen as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_warm <= '0;
        end else if (!w_warm_done) begin
            r_warm <= r_warm + 1'b1;
        end
    end

    generate
        if (EDGE_TYPE == 1) begin : g_edge_fall
            assign w_edge_raw = ~w_sync & r_prev;
        end else if (EDGE_TYPE == 2) begin : g_edge_any
            assign w_edge_raw = w_sync ^ r_prev;
        end else begin : g_edge_rise
            assign w_edge_raw = w_sync & ~r_prev;
        end
    endgenerate

    assign w_edge = w_warm_done ? w_edge_raw : '0;
    assign w_clr  = (w_wr && (address == c_ADDR_CAP)) ? writedata[WIDTH-1:0] : '0;

    // OR-ing the new edge after the clear means a coincident edge survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap  <= '0;
            r_mask <= '0;
        end else begin
            r_cap <= (r_cap & ~w_clr) | w_edge;
            if (w_wr && (address == c_ADDR_MASK)) begin
                r_mask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        w_rd_sel = '0;
        case (address)
            c_ADDR_DATA: w_rd_sel = w_sync;
            c_ADDR_MASK: w_rd_sel = r_mask;
            c_ADDR_CAP:  w_rd_sel = r_cap;
            default:     w_rd_sel = '0;
        endcase
    end

    generate
        if (WIDTH < 32) begin : g_rd_pad
            assign w_rd_ext = {{(32-WIDTH){1'b0}}, w_rd_sel};
        end else begin : g_rd_full
            assign w_rd_ext = w_rd_sel;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            r_readdata <= w_rd_ext;
        end
    end

    assign readdata = r_readdata;
    assign irq      = |(r_cap & r_mask);

endmodule

`default_nettype wire

// File: tb/tb_mandel_status_pio_in.sv
//------------------------------------------------------------------------------
// tb_mandel_status_pio_in : directed bench for mandel_status_pio_in
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mandel_status_pio_in;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        cs0, cs2;
    logic [31:0] in_port0, in_port2;
    logic [31:0] readdata0, readdata2;
    logic        irq0, irq2;
    logic [31:0] rd;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mandel_status_pio_in #(.WIDTH(32), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs0),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata0),
        .in_port    (in_port0),
        .irq        (irq0)
    );

    mandel_status_pio_in #(.WIDTH(32), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (cs2),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata2),
        .in_port    (in_port2),
        .irq        (irq2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input int which, input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        cs0       = (which == 0);
        cs2       = (which == 2);
        tick();
        cs0     = 1'b0;
        cs2     = 1'b0;
        write_n = 1'b1;
    endtask

    task automatic bus_read(input int which, input logic [1:0] a, output logic [31:0] d);
        address = a;
        write_n = 1'b1;
        cs0     = (which == 0);
        cs2     = (which == 2);
        tick();
        cs0 = 1'b0;
        cs2 = 1'b0;
        d   = (which == 0) ? readdata0 : readdata2;
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        write_n   = 1'b1;
        writedata = '0;
        cs0       = 1'b0;
        cs2       = 1'b0;
        in_port0  = 32'hFFFF_FFFF;
        in_port2  = 32'h0;
        tick(3);
        check("reset_readdata", readdata0, 32'h0);
        check("reset_irq", {31'b0, irq0}, 32'h0);

        // Release with inputs held high: no spurious capture.
        reset_n = 1'b1;
        tick(10);
        check("warmup_irq", {31'b0, irq0}, 32'h0);
        bus_read(0, 2'd3, rd); check("warmup_cap", rd, 32'h0);
        bus_read(0, 2'd0, rd); check("warmup_data", rd, 32'hFFFF_FFFF);

        // Falling edges ignored by the rising-edge instance.
        in_port0 = 32'h0;
        tick(10);
        bus_read(0, 2'd3, rd); check("fall_ignored", rd, 32'h0);

        // Capture lands exactly SYNC_STAGES+1 edges after the change.
        in_port0 = 32'h5;
        tick(2);
        bus_read(0, 2'd3, rd); check("cap_not_yet", rd, 32'h0);
        bus_read(0, 2'd3, rd); check("cap_latency", rd, 32'h5);
        check("irq_masked", {31'b0, irq0}, 32'h0);

        bus_write(0, 2'd2, 32'h4);
        check("irq_after_mask", {31'b0, irq0}, 32'h1);
        bus_write(0, 2'd3, 32'h4);
        check("irq_after_clr", {31'b0, irq0}, 32'h0);
        bus_read(0, 2'd3, rd); check("cap_after_clr", rd, 32'h1);
        bus_read(0, 2'd2, rd); check("mask_read", rd, 32'h4);

        // Edge and W1C on the same bit in the same cycle: edge wins.
        in_port0 = 32'h4;
        tick(5);
        bus_write(0, 2'd3, 32'h1);
        bus_read(0, 2'd3, rd); check("w1c_only", rd, 32'h0);
        in_port0 = 32'h5;
        tick(2);
        bus_write(0, 2'd3, 32'h1);
        bus_read(0, 2'd3, rd); check("edge_beats_clr", rd, 32'h1);

        // Writes to data and reserved locations are ignored.
        bus_write(0, 2'd0, 32'h0);
        bus_write(0, 2'd1, 32'hDEAD_BEEF);
        bus_read(0, 2'd0, rd); check("data_ro", rd, 32'h5);

        // Back-to-back reads of 0, 2, 3, 1.
        write_n = 1'b1;
        cs0     = 1'b1;
        address = 2'd0; tick(); check("b2b_data", readdata0, 32'h5);
        address = 2'd2; tick(); check("b2b_mask", readdata0, 32'h4);
        address = 2'd3; tick(); check("b2b_cap", readdata0, 32'h1);
        address = 2'd1; tick(); check("b2b_rsvd", readdata0, 32'h0);
        address = 2'd2; tick(); check("b2b_mask2", readdata0, 32'h4);
        cs0 = 1'b0;
        tick(3);
        check("readdata_hold", readdata0, 32'h4);
        bus_read(0, 2'd3, rd); check("read_no_clear", rd, 32'h1);

        // Any-edge instance: high then low leaves bit 7 set.
        in_port2 = 32'h80;
        tick(10);
        in_port2 = 32'h0;
        tick(10);
        bus_read(2, 2'd3, rd); check("any_toggle", rd, 32'h80);
        bus_write(2, 2'd3, 32'h80);
        bus_read(2, 2'd3, rd); check("any_cleared", rd, 32'h0);
        in_port2 = 32'h80;
        tick(10);
        bus_read(2, 2'd3, rd); check("any_retoggle", rd, 32'h80);

        // Build capture=0xFF with irq high, then reset asynchronously.
        bus_write(0, 2'd2, 32'hFF);
        in_port0 = 32'h0;
        tick(6);
        in_port0 = 32'hFF;
        tick(6);
        bus_read(0, 2'd3, rd); check("pre_reset_cap", rd, 32'hFF);
        check("pre_reset_irq", {31'b0, irq0}, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_irq", {31'b0, irq0}, 32'h0);
        check("async_readdata", readdata0, 32'h0);
        tick(2);
        reset_n = 1'b1;
        tick(10);
        bus_read(0, 2'd2, rd); check("post_reset_mask", rd, 32'h0);
        bus_read(0, 2'd3, rd); check("post_reset_cap", rd, 32'h0);
        check("post_reset_irq", {31'b0, irq0}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
